// File: rtl/sha_stream_if.sv
// Byte-stream bundle between NPORT requesters, the shared SHA core and the result side.
// master is the arbiter's view; slave is the view of the surrounding requesters and core.
interface sha_stream_if #(
    parameter int NPORT = 4
);
    localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [NPORT-1:0]    s_tvalid;
    logic [NPORT-1:0]    s_tready;
    logic [NPORT-1:0]    s_tlast;
    logic [NPORT*32-1:0] s_tid;
    logic [NPORT*8-1:0]  s_tdata;

    logic                m_tvalid;
    logic                m_tready;
    logic                m_tlast;
    logic [31:0]         m_tid;
    logic [7:0]          m_tdata;

    logic                c_ovalid;
    logic                res_valid;
    logic [SW-1:0]       res_src;
    logic                err;

    modport master (
        input  s_tvalid, s_tlast, s_tid, s_tdata, m_tready, c_ovalid,
        output s_tready, m_tvalid, m_tlast, m_tid, m_tdata, res_valid, res_src, err
    );

    modport slave (
        output s_tvalid, s_tlast, s_tid, s_tdata, m_tready, c_ovalid,
        input  s_tready, m_tvalid, m_tlast, m_tid, m_tdata, res_valid, res_src, err
    );
endinterface

// File: rtl/sha_stream_arbiter.sv
// Round-robin, message-locked arbiter feeding one SHA core from NPORT byte streams,
// with a FIFO of source indices that tags each core result with its originating port.
module sha_stream_arbiter #(
    parameter int NPORT  = 4,
    parameter int QDEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    sha_stream_if.master bus
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   g_q, g_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [QW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [PW-1:0]   q_mem [QDEPTH];

    logic [PW-1:0]   pick;
    logic            pick_ok;
    int              idx;
    logic            busy, beat, push, pop, q_full, q_empty;

    assign q_full  = (count_q == CW'(QDEPTH));
    assign q_empty = (count_q == '0);
    assign pop     = bus.c_ovalid && !q_empty && !rst;

    // Upward search from rr_ptr; iterating downward lets the nearest hit win.
    always_comb begin
        pick    = rr_ptr_q;
        pick_ok = 1'b0;
        idx     = 0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NPORT) idx = idx - NPORT;
            if (bus.s_tvalid[PW'(idx)]) begin
                pick_ok = 1'b1;
                pick    = PW'(idx);
            end
        end
    end

    always_comb begin
        busy          = (state_q == BUSY) && !rst;
        bus.s_tready  = '0;
        bus.m_tvalid  = 1'b0;
        bus.m_tlast   = 1'b0;
        bus.m_tid     = '0;
        bus.m_tdata   = '0;
        if (busy) begin
            bus.m_tvalid       = bus.s_tvalid[g_q];
            bus.m_tlast        = bus.s_tlast[g_q];
            bus.m_tid          = bus.s_tid[{g_q, 5'b0} +: 32];
            bus.m_tdata        = bus.s_tdata[{g_q, 3'b0} +: 8];
            bus.s_tready[g_q]  = bus.m_tready;
        end
        beat          = bus.m_tvalid && bus.m_tready;
        bus.res_valid = pop;
        bus.res_src   = q_mem[rd_ptr_q];
        bus.err       = err_q;
    end

    // Queue fullness is judged on the registered count, so a same-cycle pop never frees a grant.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        case (state_q)
            IDLE: if (pick_ok && !q_full) begin
                state_d = BUSY;
                g_d     = pick;
                push    = 1'b1;
            end
            BUSY: if (beat && bus.m_tlast) begin
                state_d  = IDLE;
                rr_ptr_d = (g_q == PW'(NPORT - 1)) ? '0 : g_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + QW'(push);
        rd_ptr_d = rd_ptr_q + QW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        err_d    = err_q | (bus.c_ovalid & q_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: queue storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr_q] <= g_d;
    end
endmodule

// File: tb/tb_sha_stream_arbiter.sv
// Directed bench for sha_stream_arbiter: a cycle-by-cycle vector table plus
// hand-written stall and mid-message reset sequences.
module tb_sha_stream_arbiter;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sha_stream_if #(.NPORT(4)) bus ();

    sha_stream_arbiter #(.NPORT(4), .QDEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       mrdy;
        logic       cov;
        logic       busy;
        logic [1:0] g;
        logic       mvld;
        logic       mlast;
        logic [3:0] srdy;
        logic       resv;
        logic [1:0] ress;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                                input logic mrdy, input logic cov, input logic busy,
                                input logic [1:0] g, input logic mvld, input logic mlast,
                                input logic [3:0] srdy, input logic resv, input logic [1:0] ress,
                                input logic err);
        vec_t v;
        v.rst = r; v.vld = vld; v.lst = lst; v.mrdy = mrdy; v.cov = cov;
        v.busy = busy; v.g = g; v.mvld = mvld; v.mlast = mlast; v.srdy = srdy;
        v.resv = resv; v.ress = ress; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                         input logic mrdy, input logic cov);
        rst          = r;
        bus.s_tvalid = vld;
        bus.s_tlast  = lst;
        bus.m_tready = mrdy;
        bus.c_ovalid = cov;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bus(input string name, input logic mvld, input logic mlast,
                              input logic [3:0] srdy, input logic [31:0] tid);
        check({name, " m_tvalid"}, {31'b0, bus.m_tvalid}, {31'b0, mvld});
        check({name, " m_tlast"},  {31'b0, bus.m_tlast},  {31'b0, mlast});
        check({name, " s_tready"}, {28'b0, bus.s_tready}, {28'b0, srdy});
        check({name, " m_tid"},    bus.m_tid,             tid);
    endtask

    initial begin
        bus.s_tid   = {32'd113, 32'd112, 32'd111, 32'd110};
        bus.s_tdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc();

        // Port 1 alone, 3-byte message, then its result; then a pop of an empty queue.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 1, 1, 1, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 1, 1, 1, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 0, 1, 1, 1, 1, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
        // All four ports contend with 2-byte messages; one backpressure cycle on port 0.
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 0, 1, 0, 1, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 1, 1, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 1, 0, 1, 1, 1, 1, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 2, 1, 0, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 1, 0, 1, 2, 1, 1, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 3, 1, 0, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1000, 1, 1, 1, 3, 1, 1, 4'b1000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 0, 1, 0, 1, 1, 4'b0001, 0, 0, 0));
        // Queue full with port 3 waiting; a pop frees it one cycle later; drain results.
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 1, 1, 3, 1, 0, 4'b1000, 1, 2, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, 1, 1, 3, 1, 1, 4'b1000, 1, 3, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 3, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].lst, tbl[i].mrdy, tbl[i].cov);
            @(negedge clk);
            expect_bus($sformatf("row%0d", i), tbl[i].mvld, tbl[i].mlast, tbl[i].srdy,
                       tbl[i].busy ? 32'd110 + 32'(tbl[i].g) : 32'd0);
            check($sformatf("row%0d m_tdata", i), {24'b0, bus.m_tdata},
                  tbl[i].busy ? {24'b0, 8'hA0 + 8'(tbl[i].g)} : 32'd0);
            check($sformatf("row%0d res_valid", i), {31'b0, bus.res_valid}, {31'b0, tbl[i].resv});
            if (tbl[i].resv)
                check($sformatf("row%0d res_src", i), {30'b0, bus.res_src}, {30'b0, tbl[i].ress});
            check($sformatf("row%0d err", i), {31'b0, bus.err}, {31'b0, tbl[i].err});
            cyc();
        end

        // Port 0 stalls mid-message for 5 cycles while port 2 waits.
        drive(1, 4'b0000, 4'b0000, 1, 0); cyc();
        drive(0, 4'b0101, 4'b0000, 1, 0); @(negedge clk);
        expect_bus("stall idle", 0, 0, 4'b0000, 32'd0); cyc();
        @(negedge clk);
        expect_bus("stall byte1", 1, 0, 4'b0001, 32'd110); cyc();
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b0100, 4'b0000, 1, 0); @(negedge clk);
            expect_bus($sformatf("stall gap%0d", k), 0, 0, 4'b0001, 32'd110); cyc();
        end
        drive(0, 4'b0101, 4'b0001, 1, 0); @(negedge clk);
        expect_bus("stall last", 1, 1, 4'b0001, 32'd110); cyc();
        drive(0, 4'b0100, 4'b0000, 1, 0); @(negedge clk);
        expect_bus("stall rearb", 0, 0, 4'b0000, 32'd0); cyc();
        @(negedge clk);
        expect_bus("stall port2", 1, 0, 4'b0100, 32'd112); cyc();

        // Reset after two bytes of port 1's message; queue, err and rr_ptr all clear.
        drive(1, 4'b0000, 4'b0000, 1, 0); cyc();
        drive(0, 4'b0011, 4'b0001, 1, 0); cyc();
        @(negedge clk);
        expect_bus("rst p0 msg", 1, 1, 4'b0001, 32'd110); cyc();
        drive(0, 4'b0011, 4'b0000, 1, 0); cyc();
        @(negedge clk);
        expect_bus("rst p1 byte1", 1, 0, 4'b0010, 32'd111); cyc();
        cyc();
        drive(1, 4'b0011, 4'b0000, 1, 0); @(negedge clk);
        expect_bus("rst during", 0, 0, 4'b0000, 32'd0); cyc();
        drive(0, 4'b0000, 4'b0000, 1, 1); @(negedge clk);
        expect_bus("rst after", 0, 0, 4'b0000, 32'd0);
        check("rst after err", {31'b0, bus.err}, 32'd0);
        check("rst after res_valid", {31'b0, bus.res_valid}, 32'd0); cyc();
        drive(0, 4'b0011, 4'b0000, 1, 0); @(negedge clk);
        check("rst empty-pop err", {31'b0, bus.err}, 32'd1); cyc();
        @(negedge clk);
        expect_bus("rst rr0 grant", 1, 0, 4'b0001, 32'd110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha_stream_arbiter.md
SHA_STREAM_ARBITER -- requirements
Module: sha_stream_arbiter

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, giving the number of requester byte-stream ports (2..8).
REQ-002 The block SHALL have parameter QDEPTH, default 4, giving the depth of the in-flight source-index queue (power of 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port s_tvalid, input, NPORT bits: per-port byte valid.
REQ-006 The block SHALL have port s_tready, output, NPORT bits: per-port byte accepted.
REQ-007 The block SHALL have port s_tlast, input, NPORT bits: per-port last byte of message.
REQ-008 The block SHALL have port s_tid, input, NPORT*32 bits: per-port message id; port k occupies bits [32k+31:32k].
REQ-009 The block SHALL have port s_tdata, input, NPORT*8 bits: per-port data byte; port k occupies bits [8k+7:8k].
REQ-010 The block SHALL have ports m_tvalid (output, 1), m_tready (input, 1), m_tlast (output, 1), m_tid (output, 32) and m_tdata (output, 8): the stream to the shared SHA core.
REQ-011 The block SHALL have port c_ovalid, input, 1 bit: the SHA core result-valid pulse.
REQ-012 The block SHALL have ports res_valid (output, 1) and res_src (output, clog2(NPORT)): the result-valid pulse and the index of the port that sent the message.
REQ-013 The block SHALL have port err, output, 1 bit: sticky flag set when c_ovalid arrives while the queue is empty.

Function
REQ-014 The block SHALL use two states: IDLE (arbitrate) and BUSY (locked to granted port g).
REQ-015 In IDLE, all s_tready bits and m_tvalid SHALL be 0.
REQ-016 In IDLE, when any s_tvalid bit is 1 and the queue is not full, the block SHALL select the first valid port searching upward from rr_ptr, wrapping modulo NPORT.
REQ-017 On that selection edge, the block SHALL register g, push g into the queue and enter BUSY, so the first byte is forwarded one cycle after IDLE sees valid.
REQ-018 In IDLE with the queue full, the block SHALL not grant and SHALL remain in IDLE.
REQ-019 In BUSY, m_tvalid, m_tlast, m_tid and m_tdata SHALL be driven combinationally from port g; s_tready[g] SHALL equal m_tready; all other s_tready bits SHALL be 0.
REQ-020 In BUSY, a beat is accepted when m_tvalid and m_tready are both 1; an accepted beat with m_tlast=1 SHALL return the block to IDLE and set rr_ptr=(g+1) mod NPORT.
REQ-021 A granted message SHALL never be interleaved with another port's bytes; gaps (s_tvalid[g]=0) in BUSY SHALL hold the grant.
REQ-022 On c_ovalid=1 with the queue non-empty, the block SHALL pop the queue and drive res_valid=1 with res_src=popped index in the same cycle, combinationally.
REQ-023 On c_ovalid=1 with the queue empty, res_valid SHALL stay 0 and err SHALL be set to 1 from the next cycle on.
REQ-024 A simultaneous push and pop SHALL leave the queue count unchanged and keep order (FIFO); the core returns results in message order.
REQ-025 A pop in the same cycle as an IDLE grant decision with the queue full SHALL not enable that grant; the grant SHALL occur one cycle later.
REQ-026 The queue count SHALL have clog2(QDEPTH)+1 bits; read and write pointers SHALL wrap modulo QDEPTH.
REQ-027 Outside BUSY, m_tlast, m_tid and m_tdata SHALL be 0.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to state IDLE with rr_ptr=0, g=0, an empty queue and err=0; res_valid, m_tvalid and s_tready SHALL be 0 during and after reset until a new grant.
REQ-029 A reset asserted mid-message SHALL abandon that message without emitting tlast; the SHA core SHALL share the same rst.

Verification
REQ-030 Only port 1 valid with a 3-byte message (id 111, tlast on the 3rd byte) -> grant on the next cycle; m_tid=111 on byte 1; m_tlast on byte 3; queue holds {1}; c_ovalid -> res_valid=1, res_src=1.
REQ-031 All 4 ports continuously valid with 2-byte messages, after reset -> grant order 0,1,2,3,0 with no interleaving; res_src sequence 0,1,2,3.
REQ-032 Port 0 stalls s_tvalid for 5 cycles mid-message while port 2 is valid -> no port-2 bytes until port 0 tlast is accepted, then port 2 is granted.
REQ-033 Four messages completed with no c_ovalid (queue full) while port 3 is valid -> no grant; a c_ovalid pulse -> res_src=oldest entry, and port 3 is granted the cycle after.
REQ-034 c_ovalid with the queue empty -> res_valid=0 and err=1 next cycle, held until rst.
REQ-035 rst asserted in BUSY after 2 bytes -> the next cycle shows IDLE, all s_tready=0, err=0, empty queue, and rr_ptr=0 (port 0 wins the next contention).
